// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave emulating the joystick: returns a 5-byte position/button report, decodes the LED command byte.
// All SPI lines are oversampled in the clk domain; clk must run at least 8x sclk.
module jstk_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_BYTES   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] btn,
    output logic [1:0] led_cmd,
    output logic       cmd_valid,
    output logic       frame_done,
    output logic       busy
);

    localparam int IW = $clog2(NUM_BYTES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES);

    typedef enum logic {IDLE, ACTIVE} state_t;

    // Bit 2 = ss, bit 1 = sclk, bit 0 = mosi
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0]                  lines;
    logic [2:0]                  hist_q;
    logic                        ss_fall, ss_rise, sclk_rise, sclk_fall;

    state_t          state, state_n;
    logic [7:0]      tx_shift, tx_n;
    logic [7:0]      rx_shift, rx_n;
    logic [3:0]      bit_cnt, bit_n;
    logic [IW-1:0]   byte_idx, idx_n;
    logic [IW-1:0]   complete_cnt, cnt_n;
    logic [9:0]      x_snap, x_snap_n;
    logic [9:0]      y_snap, y_snap_n;
    logic [2:0]      btn_snap, btn_snap_n;
    logic [1:0]      led_n;
    logic            cmd_valid_n, frame_done_n;

    assign lines     = sync_q[SYNC_STAGES-1];
    assign ss_fall   =  hist_q[2] & ~lines[2];
    assign ss_rise   = ~hist_q[2] &  lines[2];
    assign sclk_rise = ~hist_q[1] &  lines[1];
    assign sclk_fall =  hist_q[1] & ~lines[1];

    assign busy = (state == ACTIVE);
    assign miso = (state == ACTIVE) & tx_shift[7];

    function automatic logic [7:0] report_byte(input logic [IW-1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (idx < LAST_IDX) begin
            case (idx)
                IW'(0):  b = x_snap[7:0];
                IW'(1):  b = {6'b0, x_snap[9:8]};
                IW'(2):  b = y_snap[7:0];
                IW'(3):  b = {6'b0, y_snap[9:8]};
                IW'(4):  b = {5'b0, btn_snap};
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    always_comb begin
        state_n      = state;
        tx_n         = tx_shift;
        rx_n         = rx_shift;
        bit_n        = bit_cnt;
        idx_n        = byte_idx;
        cnt_n        = complete_cnt;
        x_snap_n     = x_snap;
        y_snap_n     = y_snap;
        btn_snap_n   = btn_snap;
        led_n        = led_cmd;
        cmd_valid_n  = 1'b0;
        frame_done_n = 1'b0;
        case (state)
            IDLE: begin
                // An sclk rise coinciding with the ss fall is deliberately dropped
                if (ss_fall) begin
                    x_snap_n   = x_pos;
                    y_snap_n   = y_pos;
                    btn_snap_n = btn;
                    tx_n       = x_pos[7:0];
                    bit_n      = 4'd0;
                    idx_n      = '0;
                    cnt_n      = '0;
                    state_n    = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_n      = IDLE;
                    frame_done_n = (complete_cnt >= LAST_IDX);
                end else if (sclk_rise) begin
                    rx_n = {rx_shift[6:0], hist_q[0]};
                    if (bit_cnt == 4'd7) begin
                        bit_n = 4'd0;
                        if (byte_idx != LAST_IDX)     idx_n = byte_idx + 1'b1;
                        if (complete_cnt != LAST_IDX) cnt_n = complete_cnt + 1'b1;
                        if (byte_idx == '0 && rx_n[7:2] == 6'b100000) begin
                            led_n       = rx_n[1:0];
                            cmd_valid_n = 1'b1;
                        end
                    end else begin
                        bit_n = bit_cnt + 4'd1;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt != 4'd0) tx_n = {tx_shift[6:0], 1'b0};
                    else                 tx_n = report_byte(byte_idx);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            hist_q       <= '0;
            state        <= IDLE;
            tx_shift     <= '0;
            rx_shift     <= '0;
            bit_cnt      <= '0;
            byte_idx     <= '0;
            complete_cnt <= '0;
            x_snap       <= '0;
            y_snap       <= '0;
            btn_snap     <= '0;
            led_cmd      <= 2'b00;
            cmd_valid    <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], {ss, sclk, mosi}};
            hist_q       <= lines;
            state        <= state_n;
            tx_shift     <= tx_n;
            rx_shift     <= rx_n;
            bit_cnt      <= bit_n;
            byte_idx     <= idx_n;
            complete_cnt <= cnt_n;
            x_snap       <= x_snap_n;
            y_snap       <= y_snap_n;
            btn_snap     <= btn_snap_n;
            led_cmd      <= led_n;
            cmd_valid    <= cmd_valid_n;
            frame_done   <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench for jstk_spi_responder: bit-banged SPI master at clk/16 with a scoreboard of expected report bytes.
module tb_jstk_spi_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic [9:0] x_pos = 10'h0;
    logic [9:0] y_pos = 10'h0;
    logic [2:0] btn = 3'h0;
    logic       miso;
    logic [1:0] led_cmd;
    logic       cmd_valid, frame_done, busy;

    int total = 0;
    int bad = 0;
    int cv_cnt = 0;
    int fd_cnt = 0;
    int cv0, fd0;
    logic [7:0] exp_q[$];

    jstk_spi_responder #(.SYNC_STAGES(2), .NUM_BYTES(5)) dut (
        .clk(clk), .rst(rst), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso),
        .x_pos(x_pos), .y_pos(y_pos), .btn(btn), .led_cmd(led_cmd),
        .cmd_valid(cmd_valid), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_valid)  cv_cnt++;
        if (frame_done) fd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push5(input logic [7:0] b0, input logic [7:0] b1);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h05);
    endtask

    // stop_bits: raise ss after that many sclk cycles (0 = full frame)
    // rst_bit / chg_bit: sclk index at which to pulse rst / zero x_pos (-1 = never)
    task automatic frame(input int nbytes, input logic [7:0] cmd, input logic [7:0] fill,
                         input int stop_bits, input int ncheck, input int rst_bit, input int chg_bit);
        logic [7:0] rx, tx;
        int bit_no;
        bit_no = 0;
        rx = 8'h00;
        @(negedge clk);
        ss = 1'b0;
        clk_n(8);
        for (int b = 0; b < nbytes; b++) begin
            tx = (b == 0) ? cmd : fill;
            for (int i = 7; i >= 0; i--) begin
                if (!(stop_bits > 0 && bit_no >= stop_bits)) begin
                    mosi = tx[i];
                    clk_n(8);
                    rx = {rx[6:0], miso};
                    sclk = 1'b1;
                    if (bit_no == chg_bit) x_pos = 10'h000;
                    if (bit_no == rst_bit) begin
                        rst = 1'b1;
                        clk_n(1);
                        rst = 1'b0;
                        check("rst_miso", miso, 1'b0);
                        check("rst_busy", busy, 1'b0);
                        check("rst_led", led_cmd, 2'b00);
                        check("rst_cmd_valid", cmd_valid, 1'b0);
                        check("rst_frame_done", frame_done, 1'b0);
                    end
                    clk_n(8);
                    sclk = 1'b0;
                    bit_no++;
                end
            end
            if (b < ncheck) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL scoreboard_empty byte=%0d observed=%0h", b, rx);
                end else begin
                    check($sformatf("rx_byte%0d", b), rx, exp_q.pop_front());
                end
            end
        end
        clk_n(8);
        ss = 1'b1;
        mosi = 1'b0;
        clk_n(12);
    endtask

    initial begin
        clk_n(4);
        check("reset_miso", miso, 1'b0);
        check("reset_led", led_cmd, 2'b00);
        check("reset_cmd_valid", cmd_valid, 1'b0);
        check("reset_frame_done", frame_done, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;
        clk_n(6);

        x_pos = 10'h2A5; y_pos = 10'h13C; btn = 3'b101;

        // Basic read
        cv0 = cv_cnt; fd0 = fd_cnt;
        push5(8'hA5, 8'h02);
        frame(5, 8'h83, 8'h00, 0, 5, -1, -1);
        check("basic_led", led_cmd, 2'b11);
        check("basic_cv", cv_cnt - cv0, 1);
        check("basic_fd", fd_cnt - fd0, 1);
        check("basic_busy", busy, 1'b0);

        // Invalid command byte
        cv0 = cv_cnt; fd0 = fd_cnt;
        push5(8'hA5, 8'h02);
        frame(5, 8'h43, 8'h00, 0, 5, -1, -1);
        check("inval_led", led_cmd, 2'b11);
        check("inval_cv", cv_cnt - cv0, 0);
        check("inval_fd", fd_cnt - fd0, 1);

        // ss glitch
        cv0 = cv_cnt; fd0 = fd_cnt;
        @(negedge clk); ss = 1'b0; clk_n(20); ss = 1'b1; clk_n(12);
        check("glitch_cv", cv_cnt - cv0, 0);
        check("glitch_fd", fd_cnt - fd0, 0);
        check("glitch_led", led_cmd, 2'b11);

        // Snapshot: x_pos changes during byte2
        push5(8'hA5, 8'h02);
        frame(5, 8'h00, 8'h00, 0, 5, -1, 18);
        push5(8'h00, 8'h00);
        frame(5, 8'h00, 8'h00, 0, 5, -1, -1);
        check("snap_led", led_cmd, 2'b11);
        x_pos = 10'h2A5;

        // Abort after 11 sclk cycles
        cv0 = cv_cnt; fd0 = fd_cnt;
        exp_q.push_back(8'hA5);
        frame(5, 8'h81, 8'h00, 11, 1, -1, -1);
        check("abort_led", led_cmd, 2'b01);
        check("abort_cv", cv_cnt - cv0, 1);
        check("abort_fd", fd_cnt - fd0, 0);
        cv0 = cv_cnt; fd0 = fd_cnt;
        push5(8'hA5, 8'h02);
        frame(5, 8'h80, 8'h00, 0, 5, -1, -1);
        check("post_abort_led", led_cmd, 2'b00);
        check("post_abort_fd", fd_cnt - fd0, 1);

        // Overrun: 7 bytes, extra bytes carry a valid-looking command
        cv0 = cv_cnt; fd0 = fd_cnt;
        push5(8'hA5, 8'h02);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        frame(7, 8'h82, 8'h83, 0, 7, -1, -1);
        check("over_led", led_cmd, 2'b10);
        check("over_cv", cv_cnt - cv0, 1);
        check("over_fd", fd_cnt - fd0, 1);

        // Reset during byte2
        cv0 = cv_cnt; fd0 = fd_cnt;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h02);
        frame(5, 8'h81, 8'h00, 0, 2, 20, -1);
        check("rstf_led", led_cmd, 2'b00);
        check("rstf_cv", cv_cnt - cv0, 1);
        check("rstf_fd", fd_cnt - fd0, 0);
        cv0 = cv_cnt; fd0 = fd_cnt;
        push5(8'hA5, 8'h02);
        frame(5, 8'h83, 8'h00, 0, 5, -1, -1);
        check("post_rst_led", led_cmd, 2'b11);
        check("post_rst_cv", cv_cnt - cv0, 1);
        check("post_rst_fd", fd_cnt - fd0, 1);
        check("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
